// File: rtl/corriente_pkg.sv
// Shared definitions for the current-setpoint sequencer: step size, ceiling,
// FSM state encoding and the wrap-aware setpoint update.
package corriente_pkg;

  localparam int PASO_CORRIENTE = 50;
  localparam int MAX_CORRIENTE  = 1000;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PASO    = 2'b01,
    ESPERA  = 2'b10,
    REPETIR = 2'b11
  } estado_t;

  typedef enum logic {
    DIR_AUMENTO   = 1'b0,
    DIR_DISMINUYE = 1'b1
  } dir_t;

  // Wrap is decided on the 11-bit value before any add/subtract, so the
  // 10-bit result can never overflow or underflow.
  function automatic logic [9:0] siguiente_corriente(input logic [9:0] actual,
                                                     input dir_t       dir);
    logic [10:0] ext;
    logic [10:0] res;
    ext = {1'b0, actual};
    if (dir == DIR_AUMENTO) begin
      if (ext >= 11'(MAX_CORRIENTE)) res = '0;
      else                           res = ext + 11'(PASO_CORRIENTE);
    end else begin
      if (ext < 11'(PASO_CORRIENTE)) res = 11'(MAX_CORRIENTE);
      else                           res = ext - 11'(PASO_CORRIENTE);
    end
    return res[9:0];
  endfunction

endpackage

// File: rtl/antirrebote.sv
// Button conditioner: 2-flop synchronizer followed by a debouncer that accepts
// a new level only after DEBOUNCE_CYC consecutive stable synchronized cycles.
module antirrebote #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic boton,
  output logic nivel
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only; blocking ones
  // here would let sync[1] see this cycle's sync[0] and collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= '0;
      cnt   <= '0;
      nivel <= 1'b0;
    end else begin
      sync <= {sync[0], boton};
      if (sync[1] == nivel) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        nivel <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/secuenciador_corriente.sv
// Up/down current-setpoint sequencer driven by two debounced buttons.
// Define SECUENCIADOR_AUTO_REPEAT_EN to build the hold-to-repeat path.
module secuenciador_corriente
  import corriente_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int REPEAT_CYC   = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       boton_aumento,
  input  logic       boton_disminuye,
  input  logic       enable,
  output logic [9:0] cant_corriente,
  output logic       cambio,
  output logic       ocupado
);

  logic nivel_a, nivel_d;
  logic prev_a, prev_d;
  logic sube_a, sube_d;

  estado_t estado;
  dir_t    dir;

  antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_antirrebote_aumento (
    .clk     (clk),
    .reset_n (reset_n),
    .boton   (boton_aumento),
    .nivel   (nivel_a)
  );

  antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_antirrebote_disminuye (
    .clk     (clk),
    .reset_n (reset_n),
    .boton   (boton_disminuye),
    .nivel   (nivel_d)
  );

  // Edge history runs even while disabled, so a press made with enable low
  // is consumed and never replayed once enable returns.
  assign sube_a = nivel_a & ~prev_a;
  assign sube_d = nivel_d & ~prev_d;

`ifdef SECUENCIADOR_AUTO_REPEAT_EN
  localparam int RW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  logic [RW-1:0] rep_cnt;
  logic          inhibe;
  logic          mantenido;

  assign mantenido = (dir == DIR_AUMENTO) ? (nivel_a & ~nivel_d)
                                          : (nivel_d & ~nivel_a);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado         <= IDLE;
      dir            <= DIR_AUMENTO;
      cant_corriente <= '0;
      cambio         <= 1'b0;
      ocupado        <= 1'b0;
      prev_a         <= 1'b0;
      prev_d         <= 1'b0;
`ifdef SECUENCIADOR_AUTO_REPEAT_EN
      rep_cnt        <= '0;
      inhibe         <= 1'b0;
`endif
    end else begin
      prev_a <= nivel_a;
      prev_d <= nivel_d;
      cambio <= 1'b0;

      if (!enable) begin
        estado  <= IDLE;
        ocupado <= 1'b0;
`ifdef SECUENCIADOR_AUTO_REPEAT_EN
        rep_cnt <= '0;
        inhibe  <= 1'b0;
`endif
      end else begin
        case (estado)
          IDLE: begin
            if (sube_a || sube_d) begin
              ocupado <= 1'b1;
              if (nivel_a && nivel_d) begin
                // Simultaneous buttons: no step, park until both are released.
                estado <= ESPERA;
`ifdef SECUENCIADOR_AUTO_REPEAT_EN
                inhibe <= 1'b1;
`endif
              end else begin
                estado <= PASO;
                dir    <= sube_a ? DIR_AUMENTO : DIR_DISMINUYE;
`ifdef SECUENCIADOR_AUTO_REPEAT_EN
                inhibe <= 1'b0;
`endif
              end
            end
          end

          PASO, REPETIR: begin
            cant_corriente <= siguiente_corriente(cant_corriente, dir);
            cambio         <= 1'b1;
            estado         <= ESPERA;
            ocupado        <= 1'b1;
`ifdef SECUENCIADOR_AUTO_REPEAT_EN
            rep_cnt        <= '0;
`endif
          end

          ESPERA: begin
            if (!nivel_a && !nivel_d) begin
              estado  <= IDLE;
              ocupado <= 1'b0;
`ifdef SECUENCIADOR_AUTO_REPEAT_EN
              inhibe  <= 1'b0;
              rep_cnt <= '0;
`endif
            end
`ifdef SECUENCIADOR_AUTO_REPEAT_EN
            else if (nivel_a && nivel_d) begin
              inhibe  <= 1'b1;
              rep_cnt <= '0;
            end else if (!inhibe && mantenido) begin
              if (rep_cnt == RW'(REPEAT_CYC - 1)) begin
                estado  <= REPETIR;
                rep_cnt <= '0;
              end else begin
                rep_cnt <= rep_cnt + RW'(1);
              end
            end
`endif
          end

          default: begin
            estado  <= IDLE;
            ocupado <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_secuenciador_corriente.sv
// Directed bench for secuenciador_corriente (DEBOUNCE_CYC=4, REPEAT_CYC=8);
// expectations follow SECUENCIADOR_AUTO_REPEAT_EN when it is defined.
module tb_secuenciador_corriente;

  logic       clk             = 1'b0;
  logic       reset_n         = 1'b0;
  logic       boton_aumento   = 1'b0;
  logic       boton_disminuye = 1'b0;
  logic       enable          = 1'b0;
  logic [9:0] cant_corriente;
  logic       cambio;
  logic       ocupado;

  int vectores = 0;
  int fallos   = 0;
  int pulsos   = 0;
  int base;

`ifdef SECUENCIADOR_AUTO_REPEAT_EN
  // Held 40 cycles: steps land 8, 17, 26, 35 and 44 cycles after the press.
  localparam int PULSOS_REP = 5;
  localparam int CANT_REP   = 250;
`else
  localparam int PULSOS_REP = 1;
  localparam int CANT_REP   = 50;
`endif

  secuenciador_corriente #(
    .DEBOUNCE_CYC (4),
    .REPEAT_CYC   (8)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .boton_aumento   (boton_aumento),
    .boton_disminuye (boton_disminuye),
    .enable          (enable),
    .cant_corriente  (cant_corriente),
    .cambio          (cambio),
    .ocupado         (ocupado)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cambio === 1'b1) pulsos++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectores++;
    assert (obs === exp) else begin
      fallos++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulsar(input logic a, input logic d, input int hold);
    boton_aumento   = a;
    boton_disminuye = d;
    ciclos(hold);
    boton_aumento   = 1'b0;
    boton_disminuye = 1'b0;
    ciclos(12);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no end expected end of stimulus");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    ciclos(3);
    check("reset_cant", 32'(cant_corriente), 0);
    check("reset_cambio", 32'(cambio), 0);
    check("reset_ocupado", 32'(ocupado), 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    ciclos(3);

    // First press: raw-to-update latency of 2+4+2 cycles, single pulse
    base = pulsos;
    boton_aumento = 1'b1;
    ciclos(7);
    check("latencia_antes", 32'(cant_corriente), 0);
    check("ocupado_en_paso", 32'(ocupado), 1);
    ciclos(1);
    check("latencia_cant", 32'(cant_corriente), 50);
    check("latencia_cambio", 32'(cambio), 1);
    boton_aumento = 1'b0;
    ciclos(12);
    check("primer_pulsos", 32'(pulsos - base), 1);
    check("primer_ocupado", 32'(ocupado), 0);

    // Climb to the ceiling, wrap up, wrap down
    base = pulsos;
    for (int i = 0; i < 19; i++) pulsar(1'b1, 1'b0, 8);
    check("techo", 32'(cant_corriente), 1000);
    pulsar(1'b1, 1'b0, 8);
    check("wrap_arriba", 32'(cant_corriente), 0);
    pulsar(1'b0, 1'b1, 8);
    check("wrap_abajo", 32'(cant_corriente), 1000);
    pulsar(1'b0, 1'b1, 8);
    check("baja_950", 32'(cant_corriente), 950);
    check("serie_pulsos", 32'(pulsos - base), 22);

    // Short glitches never pass the debouncer
    base = pulsos;
    repeat (5) begin
      boton_aumento = 1'b1;
      ciclos(2);
      boton_aumento = 1'b0;
      ciclos(3);
    end
    ciclos(10);
    check("glitch_cant", 32'(cant_corriente), 950);
    check("glitch_pulsos", 32'(pulsos - base), 0);

    // Reset clears the setpoint
    reset_n = 1'b0;
    ciclos(2);
    check("reset2_cant", 32'(cant_corriente), 0);
    check("reset2_ocupado", 32'(ocupado), 0);
    reset_n = 1'b1;
    ciclos(3);

    // Both buttons in the same cycle: no step, but the FSM is busy
    base = pulsos;
    boton_aumento   = 1'b1;
    boton_disminuye = 1'b1;
    ciclos(8);
    check("ambos_ocupado", 32'(ocupado), 1);
    check("ambos_cambio", 32'(cambio), 0);
    boton_aumento   = 1'b0;
    boton_disminuye = 1'b0;
    ciclos(12);
    check("ambos_cant", 32'(cant_corriente), 0);
    check("ambos_pulsos", 32'(pulsos - base), 0);
    check("ambos_libre", 32'(ocupado), 0);
    pulsar(1'b0, 1'b1, 8);
    check("baja_desde_0", 32'(cant_corriente), 1000);

    // Second button while waiting: ignored, repeat suppressed
    base = pulsos;
    boton_aumento = 1'b1;
    ciclos(8);
    boton_disminuye = 1'b1;
    ciclos(30);
    boton_aumento   = 1'b0;
    boton_disminuye = 1'b0;
    ciclos(12);
    check("segundo_cant", 32'(cant_corriente), 0);
    check("segundo_pulsos", 32'(pulsos - base), 1);

    // Long hold: auto-repeat when built in, single step otherwise
    base = pulsos;
    pulsar(1'b1, 1'b0, 40);
    check("repite_cant", 32'(cant_corriente), CANT_REP);
    check("repite_pulsos", 32'(pulsos - base), PULSOS_REP);
    check("repite_ocupado", 32'(ocupado), 0);

    // enable dropped before the debounced edge: press is not queued
    base = pulsos;
    boton_aumento = 1'b1;
    ciclos(3);
    enable = 1'b0;
    ciclos(5);
    check("enable_bajo_ocupado", 32'(ocupado), 0);
    enable = 1'b1;
    ciclos(5);
    boton_aumento = 1'b0;
    ciclos(12);
    check("enable_cant", 32'(cant_corriente), CANT_REP);
    check("enable_pulsos", 32'(pulsos - base), 0);

    // enable dropped during the PASO cycle: no update
    base = pulsos;
    boton_aumento = 1'b1;
    ciclos(7);
    enable = 1'b0;
    ciclos(1);
    check("paso_sin_enable_cant", 32'(cant_corriente), CANT_REP);
    check("paso_sin_enable_cambio", 32'(cambio), 0);
    enable = 1'b1;
    ciclos(4);
    boton_aumento = 1'b0;
    ciclos(12);
    check("paso_sin_enable_pulsos", 32'(pulsos - base), 0);

    // Reset in the middle of a hold aborts without a further step
    base = pulsos;
    boton_aumento = 1'b1;
    ciclos(12);
    check("pre_reset_cant", 32'(cant_corriente), CANT_REP + 50);
    reset_n       = 1'b0;
    boton_aumento = 1'b0;
    ciclos(3);
    check("reset3_cant", 32'(cant_corriente), 0);
    check("reset3_cambio", 32'(cambio), 0);
    check("reset3_ocupado", 32'(ocupado), 0);
    reset_n = 1'b1;
    ciclos(15);
    check("post_reset_cant", 32'(cant_corriente), 0);
    check("post_reset_pulsos", 32'(pulsos - base), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
    $finish;
  end

endmodule
